// File: rtl/int_to_flp_arbiter_if.sv
// Request/result bus of the shared integer-to-double converter arbiter.
// The DUT uses the slave modport; the requester/consumer side uses master.
interface int_to_flp_arbiter_if #(
  parameter int unsigned LOGQ = 54
);
  localparam int unsigned EXPONENT_BITS = 11;
  localparam int unsigned OVERALL_BITS  = 64;
  localparam int unsigned SP_W          = EXPONENT_BITS + 1;

  logic [LOGQ-1:0]         q0;
  logic [LOGQ-1:0]         q1;
  logic [SP_W-1:0]         scale_power0;
  logic [SP_W-1:0]         scale_power1;
  logic                    req0_valid;
  logic                    req0_ready;
  logic [LOGQ-1:0]         req0_data;
  logic                    req0_last;
  logic                    req1_valid;
  logic                    req1_ready;
  logic [LOGQ-1:0]         req1_data;
  logic                    req1_last;
  logic                    out_valid;
  logic                    out_ready;
  logic [OVERALL_BITS-1:0] out_data;
  logic                    out_id;
  logic                    out_last;
  logic                    busy;

  modport slave (
    input  q0, q1, scale_power0, scale_power1,
    input  req0_valid, req0_data, req0_last,
    input  req1_valid, req1_data, req1_last,
    input  out_ready,
    output req0_ready, req1_ready,
    output out_valid, out_data, out_id, out_last, busy
  );

  modport master (
    output q0, q1, scale_power0, scale_power1,
    output req0_valid, req0_data, req0_last,
    output req1_valid, req1_data, req1_last,
    output out_ready,
    input  req0_ready, req1_ready,
    input  out_valid, out_data, out_id, out_last, busy
  );
endinterface

// File: rtl/int_to_flp_arbiter.sv
// Round-robin burst-locked arbiter feeding one integer-to-double converter from two
// requesters, with tags tracking the converter pipeline into a credit-protected FIFO.
module int_to_flp_arbiter #(
  parameter int unsigned LOGQ       = 54,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input logic               clk,
  input logic               rst,
  int_to_flp_arbiter_if.slave bus
);
  localparam int unsigned EXPONENT_BITS = 11;
  localparam int unsigned MANT_BITS     = 52;
  localparam int unsigned OVERALL_BITS  = 64;
  localparam int unsigned SP_W          = EXPONENT_BITS + 1;
  localparam int unsigned MW            = (LOGQ > MANT_BITS + 1) ? LOGQ : MANT_BITS + 1;
  localparam int unsigned PW            = $clog2(MW) + 1;
  localparam int unsigned EW            = EXPONENT_BITS + 3;
  localparam int unsigned AW            = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW            = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned BIAS          = 1023;
  localparam int unsigned EXP_MAX       = 2047;
  localparam int unsigned ENTRY_W       = OVERALL_BITS + 2;

  localparam logic signed [EW-1:0] EXP_ZERO = '0;
  localparam logic signed [EW-1:0] EXP_TOP  = EW'(EXP_MAX);

  typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} state_e;

  typedef struct packed {
    logic            id;
    logic            last;
    logic [SP_W-1:0] sp;
    logic            vld;
  } tag_t;

  typedef struct packed {
    logic id;
    logic last;
    logic vld;
  } tag_out_t;

  state_e            state_q,    state_d;
  logic              rr_q,       rr_d;
  logic [LOGQ-1:0]   bq_q,       bq_d;
  logic [SP_W-1:0]   bsp_q,      bsp_d;
  logic [CW-1:0]     outst_q,    outst_d;
  tag_t              iss_q,      iss_d;
  logic [LOGQ-1:0]   iss_data_q, iss_data_d;
  tag_t              tag1_q,     tag1_d;
  tag_out_t          tag2_q,     tag2_d;
  logic [AW-1:0]     wr_ptr_q,   wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q,   rd_ptr_d;
  logic [CW-1:0]     fifo_cnt_q, fifo_cnt_d;
  logic [ENTRY_W-1:0] fifo_mem_q [FIFO_DEPTH];

  // Converter datapath registers (intentionally unreset; qualified by the tags)
  logic              s1_neg_q,   s1_neg_d;
  logic              s1_zero_q,  s1_zero_d;
  logic [LOGQ-1:0]   s1_mag_q,   s1_mag_d;
  logic [PW-1:0]     s1_pos_q,   s1_pos_d;
  logic [OVERALL_BITS-1:0] s2_res_q, s2_res_d;

  logic              credit_c;
  logic              ready0_c, ready1_c;
  logic              accept_c;
  logic              acc_id_c, acc_last_c;
  logic [LOGQ-1:0]   acc_data_c;
  logic              out_valid_c;
  logic              pop_c, push_c;
  logic [ENTRY_W-1:0] rd_entry_c;
  logic signed [EW-1:0] exp_c;
  logic [MW-1:0]     norm_c;
  logic [MANT_BITS-1:0] frac_c;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(FIFO_DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  // Handshake: the credit check uses the registered outstanding count only
  always_comb begin : handshake
    credit_c    = outst_q < CW'(FIFO_DEPTH);
    ready0_c    = (state_q == GRANT0) && credit_c;
    ready1_c    = (state_q == GRANT1) && credit_c;
    accept_c    = (ready0_c && bus.req0_valid) || (ready1_c && bus.req1_valid);
    acc_id_c    = ready1_c;
    acc_data_c  = ready1_c ? bus.req1_data : bus.req0_data;
    acc_last_c  = ready1_c ? bus.req1_last : bus.req0_last;
    out_valid_c = fifo_cnt_q != '0;
    pop_c       = out_valid_c && bus.out_ready;
    push_c      = tag2_q.vld;
  end

  always_comb begin : next_state
    state_d    = state_q;
    rr_d       = rr_q;
    bq_d       = bq_q;
    bsp_d      = bsp_q;
    case (state_q)
      IDLE: begin
        if (bus.req0_valid && (!bus.req1_valid || !rr_q)) begin
          state_d = GRANT0;
          bq_d    = bus.q0;
          bsp_d   = bus.scale_power0;
        end else if (bus.req1_valid) begin
          state_d = GRANT1;
          bq_d    = bus.q1;
          bsp_d   = bus.scale_power1;
        end
      end
      GRANT0: begin
        if (accept_c && acc_last_c) begin
          state_d = IDLE;
          rr_d    = 1'b1;
        end
      end
      GRANT1: begin
        if (accept_c && acc_last_c) begin
          state_d = IDLE;
          rr_d    = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    outst_d    = outst_q + CW'(accept_c) - CW'(pop_c);
    iss_d      = '{id: acc_id_c, last: acc_last_c, sp: bsp_q, vld: accept_c};
    iss_data_d = acc_data_c;
    tag1_d     = iss_q;
    tag2_d     = '{id: tag1_q.id, last: tag1_q.last, vld: tag1_q.vld};
    wr_ptr_d   = push_c ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d   = pop_c ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    fifo_cnt_d = fifo_cnt_q + CW'(push_c) - CW'(pop_c);
  end

  // Converter stage A: centre the residue into (-q/2, q/2] and locate its leading one
  always_comb begin : conv_stage_a
    s1_neg_d  = iss_data_q > (bq_q >> 1);
    s1_mag_d  = s1_neg_d ? (bq_q - iss_data_q) : iss_data_q;
    s1_zero_d = s1_mag_d == '0;
    s1_pos_d  = '0;
    for (int i = 0; i < int'(LOGQ); i++) begin
      if (s1_mag_d[i]) s1_pos_d = PW'(i);
    end
  end

  // Converter stage B: exponent uses the element's own scale from tag stage 1
  always_comb begin : conv_stage_b
    exp_c    = $signed(EW'(s1_pos_q)) + $signed(EW'($signed(tag1_q.sp))) + $signed(EW'(BIAS));
    norm_c   = MW'(s1_mag_q) << (PW'(MW - 1) - s1_pos_q);
    frac_c   = MANT_BITS'(norm_c >> (MW - 1 - MANT_BITS));
    s2_res_d = {s1_neg_q, EXPONENT_BITS'(exp_c), frac_c};
    if (s1_zero_q || (exp_c <= EXP_ZERO)) begin
      s2_res_d = {s1_neg_q && !s1_zero_q, (OVERALL_BITS - 1)'(0)};
    end else if (exp_c >= EXP_TOP) begin
      s2_res_d = {s1_neg_q, {EXPONENT_BITS{1'b1}}, MANT_BITS'(0)};
    end
  end

  always_ff @(posedge clk) begin : ctrl_regs
    if (rst) begin
      state_q    <= IDLE;
      rr_q       <= 1'b0;
      bq_q       <= '0;
      bsp_q      <= '0;
      outst_q    <= '0;
      iss_q      <= '0;
      tag1_q     <= '0;
      tag2_q     <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_q       <= rr_d;
      bq_q       <= bq_d;
      bsp_q      <= bsp_d;
      outst_q    <= outst_d;
      iss_q      <= iss_d;
      tag1_q     <= tag1_d;
      tag2_q     <= tag2_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fifo_cnt_q <= fifo_cnt_d;
    end
  end

  always_ff @(posedge clk) begin : data_regs
    iss_data_q <= iss_data_d;
    s1_neg_q   <= s1_neg_d;
    s1_zero_q  <= s1_zero_d;
    s1_mag_q   <= s1_mag_d;
    s1_pos_q   <= s1_pos_d;
    s2_res_q   <= s2_res_d;
    if (push_c) fifo_mem_q[wr_ptr_q] <= {s2_res_q, tag2_q.id, tag2_q.last};
  end

  assert property (@(posedge clk) disable iff (rst)
    !(push_c && (fifo_cnt_q == CW'(FIFO_DEPTH))))
    else $error("output FIFO push while full");

  // First-word fall-through read; id/last forced low while the FIFO is empty
  assign rd_entry_c     = fifo_mem_q[rd_ptr_q];
  assign bus.req0_ready = ready0_c;
  assign bus.req1_ready = ready1_c;
  assign bus.out_valid  = out_valid_c;
  assign bus.out_data   = rd_entry_c[ENTRY_W-1:2];
  assign bus.out_id     = out_valid_c && rd_entry_c[1];
  assign bus.out_last   = out_valid_c && rd_entry_c[0];
  assign bus.busy       = (state_q != IDLE) || (outst_q != '0);
endmodule

// File: tb/tb_int_to_flp_arbiter.sv
// Randomized bench for int_to_flp_arbiter with a queue-based behavioural reference
// model that predicts handshakes, latency and every converted double.
module tb_int_to_flp_arbiter;
  localparam int unsigned LOGQ  = 54;
  localparam int unsigned DEPTH = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int_to_flp_arbiter_if #(.LOGQ(LOGQ)) bus ();

  int_to_flp_arbiter #(.LOGQ(LOGQ), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int mode  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Real-valued reference: centred residue times 2^sp, as an IEEE double
  function automatic logic [63:0] expected_bits(input longint unsigned q,
                                                input longint unsigned x, input int sp);
    longint v;
    real r, f;
    v = (x > (q >> 1)) ? -longint'(q - x) : longint'(x);
    r = v;
    f = 1.0;
    if (sp >= 0) repeat (sp) f = f * 2.0;
    else repeat (-sp) f = f / 2.0;
    return $realtobits(r * f);
  endfunction

  typedef struct {
    longint   t;
    logic [63:0] data;
    bit       id;
    bit       last;
  } exp_t;

  exp_t   eq[$];
  int     owner = -1;
  bit     rr    = 1'b0;
  longint cyc   = 0;
  bit     armed = 1'b0;
  longint unsigned mq;
  int     msp;

  // Reference model: advances once per clock from the driven inputs only
  always @(posedge clk) begin
    bit r0, r1, acc, aid, alast, pop;
    longint unsigned adata;
    if (rst) begin
      owner = -1;
      rr    = 1'b0;
      eq.delete();
      armed = 1'b1;
    end else if (armed) begin
      r0    = (owner == 0) && (eq.size() < DEPTH);
      r1    = (owner == 1) && (eq.size() < DEPTH);
      acc   = (r0 && bus.req0_valid) || (r1 && bus.req1_valid);
      aid   = r1;
      adata = r1 ? longint'(bus.req1_data) : longint'(bus.req0_data);
      alast = r1 ? bus.req1_last : bus.req0_last;
      pop   = bus.out_ready && (eq.size() > 0) && (eq[0].t <= cyc);
      if (pop) void'(eq.pop_front());
      if (acc) eq.push_back('{cyc + 4, expected_bits(mq, adata, msp), aid, alast});
      if (owner == -1) begin
        if (bus.req0_valid && (!bus.req1_valid || rr == 1'b0)) begin
          owner = 0;
          mq    = longint'(bus.q0);
          msp   = int'($signed(bus.scale_power0));
        end else if (bus.req1_valid) begin
          owner = 1;
          mq    = longint'(bus.q1);
          msp   = int'($signed(bus.scale_power1));
        end
      end else if (acc && alast) begin
        rr    = (owner == 0);
        owner = -1;
      end
    end
    cyc++;
  end

  // Every-cycle comparison of all outputs against the model
  always @(negedge clk) begin
    bit ev;
    if (armed) begin
      ev = (eq.size() > 0) && (eq[0].t <= cyc);
      chk("req0_ready", bus.req0_ready, (owner == 0) && (eq.size() < DEPTH));
      chk("req1_ready", bus.req1_ready, (owner == 1) && (eq.size() < DEPTH));
      chk("out_valid", bus.out_valid, ev);
      chk("busy", bus.busy, (owner != -1) || (eq.size() != 0));
      if (ev) begin
        chk("out_data", bus.out_data, eq[0].data);
        chk("out_id", bus.out_id, eq[0].id);
        chk("out_last", bus.out_last, eq[0].last);
      end
    end
  end

  initial begin
    bus.out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (mode)
        1:       bus.out_ready = 1'b1;
        2:       bus.out_ready = ($urandom_range(0, 99) < 70);
        default: bus.out_ready = 1'b0;
      endcase
    end
  end

  task automatic set_req(input int id, input bit v, input logic [LOGQ-1:0] d, input bit l);
    if (id == 0) begin
      bus.req0_valid = v; bus.req0_data = d; bus.req0_last = l;
    end else begin
      bus.req1_valid = v; bus.req1_data = d; bus.req1_last = l;
    end
  endtask

  function automatic logic [LOGQ-1:0] rand_q();
    logic [63:0] r;
    if ($urandom_range(0, 3) == 0) return LOGQ'($urandom_range(2, 1000));
    r = {$urandom, $urandom};
    r = r & 64'h003F_FFFF_FFFF_FFFF;
    if (r < 64'd2) r = 64'd2;
    return LOGQ'(r);
  endfunction

  function automatic logic signed [11:0] rand_sp();
    int t;
    t = int'($urandom_range(0, 1900)) - 1000;
    return 12'(t);
  endfunction

  // One burst of n beats; caller sits just after a rising edge
  task automatic drive_burst(input int id, input int n, input logic [LOGQ-1:0] q,
                             input logic signed [11:0] sp, input int gap_pct, input longint fixed);
    bit fire;
    int waited;
    logic [LOGQ-1:0] d;
    if (id == 0) begin bus.q0 = q; bus.scale_power0 = sp; end
    else begin bus.q1 = q; bus.scale_power1 = sp; end
    for (int b = 0; b < n; b++) begin
      while ($urandom_range(0, 99) < gap_pct) begin
        set_req(id, 1'b0, '0, 1'b0);
        @(posedge clk); #1;
      end
      d = (fixed >= 0) ? LOGQ'(fixed) : LOGQ'({$urandom, $urandom} % longint'(q));
      set_req(id, 1'b1, d, b == n - 1);
      fire = 1'b0;
      waited = 0;
      while (!fire && waited < 500) begin
        @(negedge clk);
        fire = (id == 0) ? (bus.req0_valid && bus.req0_ready) : (bus.req1_valid && bus.req1_ready);
        @(posedge clk); #1;
        waited++;
      end
      if (!fire) begin
        chk("beat_accept_timeout", 64'(waited), 64'(0));
        b = n;
      end
    end
    set_req(id, 1'b0, '0, 1'b0);
  endtask

  task automatic drain();
    int k = 0;
    mode = 1;
    while ((eq.size() != 0 || owner != -1) && k < 400) begin
      @(posedge clk);
      k++;
    end
    #1;
    chk("drain_done", 64'(eq.size()), 64'(0));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit fire;
    int cnt;
    rst = 1'b1;
    bus.q0 = '0; bus.q1 = '0; bus.scale_power0 = '0; bus.scale_power1 = '0;
    set_req(0, 1'b0, '0, 1'b0);
    set_req(1, 1'b0, '0, 1'b0);

    // Literal anchors for the reference conversion
    chk("model_pos", expected_bits(97, 3, -40), 64'h3D88_0000_0000_0000);
    chk("model_neg", expected_bits(97, 95, -40), 64'hBD80_0000_0000_0000);
    chk("model_zero", expected_bits(97, 0, -40), 64'h0);
    chk("model_half", expected_bits(97, 48, 0), 64'h4048_0000_0000_0000);
    chk("model_wrap", expected_bits(97, 49, 0), 64'hC048_0000_0000_0000);

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req0_ready", bus.req0_ready, 0);
    chk("rst_req1_ready", bus.req1_ready, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_id", bus.out_id, 0);
    chk("rst_out_last", bus.out_last, 0);
    chk("rst_busy", bus.busy, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Single beat with exact latency
    mode = 1;
    bus.q0 = LOGQ'(97); bus.scale_power0 = -12'sd40;
    set_req(0, 1'b1, LOGQ'(3), 1'b1);
    fire = 1'b0;
    for (int k = 0; k < 20 && !fire; k++) begin
      @(negedge clk);
      fire = bus.req0_valid && bus.req0_ready;
      @(posedge clk); #1;
    end
    set_req(0, 1'b0, '0, 1'b0);
    chk("single_accept", fire, 1);
    repeat (3) @(negedge clk);
    chk("single_c3_valid", bus.out_valid, 0);
    @(negedge clk);
    chk("single_c4_valid", bus.out_valid, 1);
    chk("single_c4_data", bus.out_data, 64'h3D88_0000_0000_0000);
    chk("single_c4_id", bus.out_id, 0);
    chk("single_c4_last", bus.out_last, 1);
    @(posedge clk); #1;
    drain();

    // Negative mapping and zero on requester 1
    drive_burst(1, 1, LOGQ'(97), -12'sd40, 0, 95);
    drive_burst(1, 1, LOGQ'(97), -12'sd40, 0, 0);
    drain();

    // Contention with scale switch in flight
    fork
      begin
        drive_burst(0, 4, rand_q(), -12'sd10, 0, -1);
        drive_burst(0, 4, rand_q(), -12'sd10, 0, -1);
      end
      begin
        drive_burst(1, 4, rand_q(), -12'sd20, 0, -1);
        drive_burst(1, 4, rand_q(), -12'sd20, 0, -1);
      end
    join
    drain();

    // Backpressure: credits stop the burst at the FIFO depth
    mode = 0;
    repeat (2) begin @(posedge clk); #1; end
    cnt = 0;
    fork
      drive_burst(0, 20, rand_q(), rand_sp(), 0, -1);
      begin
        repeat (40) begin
          @(negedge clk);
          if (bus.req0_valid && bus.req0_ready) cnt++;
        end
        chk("bp_accepted", 64'(cnt), 64'(DEPTH));
        chk("bp_ready_low", bus.req0_ready, 0);
        mode = 1;
      end
    join
    drain();

    // Reset in the middle of a burst
    cnt = 0;
    fork
      drive_burst(1, 6, rand_q(), rand_sp(), 0, -1);
      begin
        for (int k = 0; k < 100 && cnt < 2; k++) begin
          @(negedge clk);
          if (bus.req1_valid && bus.req1_ready) cnt++;
        end
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_busy", bus.busy, 0);
        chk("mid_rst_out_valid", bus.out_valid, 0);
        chk("mid_rst_out_id", bus.out_id, 0);
      end
    join
    drain();

    // Randomized traffic on both requesters with random backpressure
    mode = 2;
    fork
      for (int b = 0; b < 40; b++) begin
        drive_burst(0, int'($urandom_range(1, 8)), rand_q(), rand_sp(),
                    int'($urandom_range(0, 50)), -1);
        repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
      end
      for (int b = 0; b < 40; b++) begin
        drive_burst(1, int'($urandom_range(1, 8)), rand_q(), rand_sp(),
                    int'($urandom_range(0, 50)), -1);
        repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
      end
    join
    drain();

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
